booth_seq_ctrl: RTL and testbench

Sequential radix-2 Booth controller for the signed 8x8 multiplier. It accepts an operand pair over a valid/ready handshake and runs N Booth iterations through one shared external 9-bit ripple adder (`NineBitAdder`), driving that adder's A/B/Cin each cycle and consuming its Sum. It returns a 2N-bit signed product over a second valid/ready handshake. It replaces an N-adder array with one adder plus N cycles of reuse.

---
 rtl/booth_seq_ctrl_if.sv | 44 ++++
 rtl/booth_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if -- bundle of the Booth controller's operand/product
// handshakes and its connection to the shared external N+1-bit adder.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The sender keeps valid and data stable
// until that edge. The controller raises in_ready only in IDLE and out_valid
// only in DONE.
//
// Signals:
//   in_valid/in_ready/mcand/mplier   operand channel (tb -> controller)
//   out_valid/out_ready/product      product channel (controller -> tb)
//   add_a/add_b/add_cin              adder operands driven by the controller
//   add_sum                          adder result, combinational from add_*
//   add_en                           iteration performs a real add/subtract
//   dbg_state                        controller FSM state, for observation
//
// Modports: slave = controller side, master = environment side.
interface booth_seq_ctrl_if #(parameter int N = 8);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic [N:0]     add_a;
  logic [N:0]     add_b;
  logic           add_cin;
  logic [N:0]     add_sum;
  logic           add_en;
  logic [1:0]     dbg_state;

  modport slave (
    input  in_valid, mcand, mplier, out_ready, add_sum,
    output in_ready, out_valid, product, add_a, add_b, add_cin, add_en,
           dbg_state
  );

  modport master (
    output in_valid, mcand, mplier, out_ready, add_sum,
    input  in_ready, out_valid, product, add_a, add_b, add_cin, add_en,
           dbg_state
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl -- sequential radix-2 Booth multiplier controller.
// Accepts a signed N x N operand pair, runs N Booth iterations through one
// shared external N+1-bit adder (one iteration per cycle) and returns the
// signed 2N-bit product.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; discards any in-flight operation
//   bus   booth_seq_ctrl_if.slave: operand/product handshakes, adder
//         connection (add_a/add_b/add_cin out, add_sum in), add_en hint and
//         dbg_state (0=IDLE, 1=CALC, 2=DONE)
module booth_seq_ctrl #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  booth_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [N:0]    acc;
  logic [N-1:0]  q;
  logic          qm1;
  logic [N:0]    m;
  logic [CW-1:0] cnt;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.product   = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    bus.add_en    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        // Booth recoding of {q[0], qm1}: 01 adds m, 10 subtracts m as
        // ~m + 1; 00/11 pass acc through the adder unchanged.
        case ({q[0], qm1})
          2'b01: begin
            bus.add_b  = m;
            bus.add_en = 1'b1;
          end
          2'b10: begin
            bus.add_b   = ~m;
            bus.add_cin = 1'b1;
            bus.add_en  = 1'b1;
          end
          default: ;
        endcase
        if (cnt == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.product   = {acc[N-1:0], q};
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
      qm1 <= 1'b0;
      m   <= '0;
      cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc <= '0;
            q   <= bus.mplier;
            qm1 <= 1'b0;
            m   <= {bus.mcand[N-1], bus.mcand};
            cnt <= '0;
          end
        end
        CALC: begin
          // Arithmetic shift right of {add_sum, q, qm1}; the adder carry-out
          // is dropped since the N+1-bit accumulator cannot overflow.
          acc <= {bus.add_sum[N], bus.add_sum[N:1]};
          q   <= {bus.add_sum[0], q[N-1:1]};
          qm1 <= q[0];
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.add_a     = acc;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl -- self-checking bench for booth_seq_ctrl.
// Models the external 9-bit adder, drives directed and random operand pairs,
// and checks the product against signed integer multiplication and the
// per-iteration adder controls against Booth recoding of the multiplier bits.
module tb_booth_seq_ctrl;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_seq_ctrl_if #(.N(N)) bif ();

  booth_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // External NineBitAdder: carry-out discarded
  assign bif.add_sum = bif.add_a + bif.add_b + {{N{1'b0}}, bif.add_cin};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},  32'(bif.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bif.out_valid), 32'd0);
    check({tag, "_product"},   32'(bif.product),   32'd0);
    check({tag, "_add_a"},     32'(bif.add_a),     32'd0);
    check({tag, "_add_b"},     32'(bif.add_b),     32'd0);
    check({tag, "_add_cin"},   32'(bif.add_cin),   32'd0);
    check({tag, "_add_en"},    32'(bif.add_en),    32'd0);
  endtask

  // One operation; called and returns at a negedge. abort_at >= 0 asserts rst
  // in that CALC iteration instead of completing.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input int hold, input bit noise, input int abort_at);
    logic [2*N-1:0] exp_q[$];
    logic [N:0]     mext;
    logic [N:0]     exp_b;
    logic [2*N-1:0] exp_p;
    logic           prev;
    int             ia;
    int             ib;
    ia   = $signed(a);
    ib   = $signed(b);
    exp_p = 16'(ia * ib);
    mext = {a[N-1], a};
    exp_q.push_back(exp_p);

    check("accept_in_ready", 32'(bif.in_ready), 32'd1);
    bif.in_valid = 1'b1;
    bif.mcand    = a;
    bif.mplier   = b;

    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (noise) begin
        bif.mcand  = N'($urandom);
        bif.mplier = N'($urandom);
      end else begin
        bif.in_valid = 1'b0;
      end
      prev = (i == 0) ? 1'b0 : b[i-1];
      case ({b[i], prev})
        2'b01:   exp_b = mext;
        2'b10:   exp_b = ~mext;
        default: exp_b = '0;
      endcase
      check("calc_add_en",    32'(bif.add_en),  32'(b[i] ^ prev));
      check("calc_add_cin",   32'(bif.add_cin), 32'(b[i] & ~prev));
      check("calc_add_b",     32'(bif.add_b),   32'(exp_b));
      check("calc_out_valid", 32'(bif.out_valid), 32'd0);
      check("calc_in_ready",  32'(bif.in_ready),  32'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        check_idle_zero("abort_hold");
        rst = 1'b0;
        bif.in_valid = 1'b0;
        void'(exp_q.pop_front());
        return;
      end
    end

    @(negedge clk);
    bif.in_valid = 1'b0;
    check("done_out_valid", 32'(bif.out_valid), 32'd1);
    check("done_product",   32'(bif.product),   32'(exp_q[0]));
    check("done_in_ready",  32'(bif.in_ready),  32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bif.out_valid), 32'd1);
      check("hold_product",   32'(bif.product),   32'(exp_q[0]));
      check("hold_in_ready",  32'(bif.in_ready),  32'd0);
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    void'(exp_q.pop_front());
    check("ret_in_ready",  32'(bif.in_ready),  32'd1);
    check("ret_out_valid", 32'(bif.out_valid), 32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bif.in_valid  = 1'b1;
    bif.mcand     = 8'h12;
    bif.mplier    = 8'h34;
    bif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    check("reset_state", 32'(bif.dbg_state), 32'd0);
    rst = 1'b0;

    // Directed cases; first accept is on the first edge after reset release
    do_op(8'd3,   8'd5,   0, 1'b0, -1);
    do_op(8'hF9,  8'd6,   1, 1'b1, -1);
    do_op(8'd127, 8'h80,  0, 1'b0, -1);
    do_op(8'h80,  8'h80,  2, 1'b1, -1);
    do_op(8'h5A,  8'h00,  0, 1'b0, -1);
    do_op(8'hC3,  8'h55,  0, 1'b0, -1);
    do_op(8'h11,  8'hEE,  5, 1'b1, -1);
    do_op(8'd9,   8'd9,   0, 1'b1, 4);
    do_op(8'd2,   8'd3,   0, 1'b0, -1);
    do_op(8'h7F,  8'h7F,  0, 1'b0, -1);
    do_op(8'h80,  8'h7F,  0, 1'b0, -1);
    do_op(8'hFF,  8'hFF,  0, 1'b0, -1);

    // Random cases
    for (int r = 0; r < 60; r++) begin
      do_op(N'($urandom), N'($urandom), $urandom_range(0, 3),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, N - 1) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
